mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
- Multi-cycle control sequencer for the MIPS-subset CPU datapath: PC, NPC, RF, EXT, ALU, GPR/WD muxes, plus a shared unified instruction/data memory.
- A Moore FSM steps each instruction through FETCH/DECODE/EXE/MEM/WB. Every datapath select and write-enable is driven from the current state and the latched opcode/funct.
- Memory accesses use a req/ready handshake, so wait states are tolerated.
- The block also counts retired instructions and flags illegal opcodes.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all flops are rising-edge.
- rst  in  1  reset; asynchronous, active-low.
- op  in  6  IR[31:26]; valid from DECODE onward.
- funct  in  6  IR[5:0].
- zero  in  1  ALU Zero flag.
- mem_ready  in  1  memory has completed the current request this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  write strobe, qualified by mem_req.
- iord  out  1  address select: 0 = PC, 1 = ALUOut.
- ir_write  out  1  load IR.
- pc_write  out  1  load PC from NPC.
- reg_write  out  1  RF write enable.
- alu_src_a  out  1  0 = RD1, 1 = shamt.
- alu_src_b  out  1  0 = RD2, 1 = Imm32.
- ext_op  out  1  1 = sign-extend, 0 = zero-extend.
- alu_op  out  4  ALU operation code.
- npc_op  out  2  PLUS4, BRANCH, JUMP, JR.
- wd_sel  out  2  register write data: ALU, MEM, PC (link).
- gpr_sel  out  2  write address: RD, RT, R31.
- illegal  out  1  sticky illegal-instruction flag.
- retire  out  1  one-cycle pulse when an instruction completes.
- instr_cnt  out  CNT_W  count of retired instructions.
- state_o  out  3  current state, for debug.

Behaviour:
- Reset (rst=0):
  - state = IDLE, illegal = 0, instr_cnt = 0.
  - All enables and strobes are 0; all selects are 0.
  - Reset asserted mid-instruction aborts it immediately; no write is issued.
- States and transitions:
  - IDLE(0) -> FETCH unconditionally.
  - FETCH(1):
    - Outputs: mem_req=1, iord=0, npc_op=PLUS4.
    - ir_write and pc_write = mem_ready.
    - Stay in FETCH while mem_ready=0; go to DECODE on mem_ready.
  - DECODE(2):
    - Legal op/funct -> EXE.
    - Illegal -> TRAP, setting illegal=1.
  - EXE(3), by instruction class:
    - R-ALU: alu_op from funct (add, sub, and, or, slt, sll, srl; shifts set alu_src_a=1) -> WB.
    - addi/ori/lui/lw/sw: alu_src_b=1; ext_op=0 only for ori/lui. addi/ori/lui -> WB; lw/sw -> MEM.
    - beq/bne: alu_op=SUB, npc_op=BRANCH. pc_write = zero (beq) or !zero (bne). retire=1 -> FETCH.
    - j: npc_op=JUMP, pc_write=1, retire -> FETCH.
    - jal: as j, plus reg_write=1, gpr_sel=R31, wd_sel=PC (PC here is already PC+4). retire -> FETCH.
    - jr: npc_op=JR, pc_write=1, retire -> FETCH.
  - MEM(4):
    - Outputs: mem_req=1, iord=1, mem_we=1 for sw.
    - Hold in MEM until mem_ready.
    - sw with mem_ready: retire -> FETCH.
    - lw with mem_ready -> WB.
  - WB(5):
    - reg_write=1, retire=1 -> FETCH.
    - gpr_sel: RD for R-type, RT otherwise.
    - wd_sel: MEM for lw, ALU otherwise.
  - TRAP(6): all outputs 0; stays until reset.
- Latency with mem_ready tied high: R-type/addi 4 cycles; lw 5; sw 4; branch/jump 3.
- Write-enable discipline: reg_write, pc_write, ir_write and mem_we are never asserted in the same cycle as a stalled (mem_ready=0) request, except mem_we, which is held until ready.
- Counter: instr_cnt increments on retire and wraps modulo 2^CNT_W.
- Handshake: mem_req and iord are stable from assertion until the ready cycle; mem_ready is ignored outside FETCH/MEM.

Decomposition:
- Package mc_pkg holds:
  - opcode and funct constants;
  - ALU_* codes (ADD, SUB, AND, OR, SLT, SLL, SRL, LUI);
  - NPC_*, WD_*, GPR_* encodings;
  - the state enum.
- One sub-module, mc_decode: purely combinational op/funct -> instruction class, alu_op, ext_op, legal.

Test Plan:
- Release rst with mem_ready=1 and execute add -> IDLE, FETCH, DECODE, EXE, WB; reg_write=1 only in WB, with gpr_sel=RD and wd_sel=ALU; instr_cnt=1.
- lw with mem_ready low for 3 cycles in MEM -> mem_req/iord held 4 cycles; WB follows with wd_sel=MEM and gpr_sel=RT; total 8 cycles.
- beq with zero=1, then zero=0 -> pc_write=1, then 0, in EXE; both retire after 3 cycles.
- jal -> in EXE: reg_write=1, gpr_sel=R31, wd_sel=PC, npc_op=JUMP, pc_write=1.
- op=6'h3F -> illegal=1, state_o=6, no further outputs; drive rst=0 mid-MEM -> all outputs 0 asynchronously and instr_cnt=0.
- Preload instr_cnt=32'hFFFFFFFF via 2^32 retires (force) then retire once -> instr_cnt=0.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control sequencer:
// opcode/funct values, datapath select codes, FSM states and instruction classes.
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SLT = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;
  localparam logic [3:0] ALU_SRL = 4'd6;
  localparam logic [3:0] ALU_LUI = 4'd7;

  localparam logic [1:0] NPC_PLUS4  = 2'd0;
  localparam logic [1:0] NPC_BRANCH = 2'd1;
  localparam logic [1:0] NPC_JUMP   = 2'd2;
  localparam logic [1:0] NPC_JR     = 2'd3;

  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_MEM = 2'd1;
  localparam logic [1:0] WD_PC  = 2'd2;

  localparam logic [1:0] GPR_RD  = 2'd0;
  localparam logic [1:0] GPR_RT  = 2'd1;
  localparam logic [1:0] GPR_R31 = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXE    = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_e;

  typedef enum logic [3:0] {
    C_RALU = 4'd0,
    C_IMM  = 4'd1,
    C_LW   = 4'd2,
    C_SW   = 4'd3,
    C_BEQ  = 4'd4,
    C_BNE  = 4'd5,
    C_J    = 4'd6,
    C_JAL  = 4'd7,
    C_JR   = 4'd8,
    C_ILL  = 4'd9
  } cls_e;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder: op/funct to instruction class, ALU
// operation, extension mode and shift-source select.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output cls_e       cls_o,
  output logic [3:0] alu_op_o,
  output logic       ext_op_o,
  output logic       shift_o,
  output logic       legal_o
);

  // Zero-extension is only used by ori/lui; everything else sign-extends.
  always_comb begin
    cls_o    = C_ILL;
    alu_op_o = ALU_ADD;
    ext_op_o = 1'b1;
    shift_o  = 1'b0;
    case (op_i)
      OP_RTYPE: begin
        cls_o = C_RALU;
        case (funct_i)
          FN_ADD:  alu_op_o = ALU_ADD;
          FN_SUB:  alu_op_o = ALU_SUB;
          FN_AND:  alu_op_o = ALU_AND;
          FN_OR:   alu_op_o = ALU_OR;
          FN_SLT:  alu_op_o = ALU_SLT;
          FN_SLL:  begin alu_op_o = ALU_SLL; shift_o = 1'b1; end
          FN_SRL:  begin alu_op_o = ALU_SRL; shift_o = 1'b1; end
          FN_JR:   cls_o = C_JR;
          default: cls_o = C_ILL;
        endcase
      end
      OP_ADDI: cls_o = C_IMM;
      OP_ORI:  begin cls_o = C_IMM; alu_op_o = ALU_OR;  ext_op_o = 1'b0; end
      OP_LUI:  begin cls_o = C_IMM; alu_op_o = ALU_LUI; ext_op_o = 1'b0; end
      OP_LW:   cls_o = C_LW;
      OP_SW:   cls_o = C_SW;
      OP_BEQ:  begin cls_o = C_BEQ; alu_op_o = ALU_SUB; end
      OP_BNE:  begin cls_o = C_BNE; alu_op_o = ALU_SUB; end
      OP_J:    cls_o = C_J;
      OP_JAL:  cls_o = C_JAL;
      default: cls_o = C_ILL;
    endcase
  end

  assign legal_o = (cls_o != C_ILL);

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle Moore control sequencer: FETCH/DECODE/EXE/MEM/WB with a
// req/ready memory handshake, retired-instruction counter and sticky trap.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic             alu_src_b,
  output logic             ext_op,
  output logic [3:0]       alu_op,
  output logic [1:0]       npc_op,
  output logic [1:0]       wd_sel,
  output logic [1:0]       gpr_sel,
  output logic             illegal,
  output logic             retire,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [2:0]       state_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [5:0]       op_q, op_d, funct_q, funct_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [5:0] dec_op, dec_funct;
  cls_e       dec_cls;
  logic [3:0] dec_alu;
  logic       dec_ext, dec_shift, dec_legal;

  // IR is decoded live in DECODE and from the latched copy afterwards.
  assign dec_op    = (state_q == S_DECODE) ? op    : op_q;
  assign dec_funct = (state_q == S_DECODE) ? funct : funct_q;
  assign op_d      = (state_q == S_DECODE) ? op    : op_q;
  assign funct_d   = (state_q == S_DECODE) ? funct : funct_q;

  mc_decode u_decode (
    .op_i     (dec_op),
    .funct_i  (dec_funct),
    .cls_o    (dec_cls),
    .alu_op_o (dec_alu),
    .ext_op_o (dec_ext),
    .shift_o  (dec_shift),
    .legal_o  (dec_legal)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      op_q      <= 6'd0;
      funct_q   <= 6'd0;
      illegal_q <= 1'b0;
      cnt_q     <= {CNT_W{1'b0}};
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      funct_q   <= funct_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    iord      = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    reg_write = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = 1'b0;
    ext_op    = 1'b0;
    alu_op    = ALU_ADD;
    npc_op    = NPC_PLUS4;
    wd_sel    = WD_ALU;
    gpr_sel   = GPR_RD;
    retire    = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_req  = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
        if (mem_ready) state_d = S_DECODE;
        else           state_d = S_FETCH;
      end
      S_DECODE: begin
        if (dec_legal) begin
          state_d = S_EXE;
        end else begin
          state_d   = S_TRAP;
          illegal_d = 1'b1;
        end
      end
      S_EXE: begin
        alu_op    = dec_alu;
        ext_op    = dec_ext;
        alu_src_a = dec_shift;
        case (dec_cls)
          C_RALU: state_d = S_WB;
          C_IMM:  begin alu_src_b = 1'b1; state_d = S_WB;  end
          C_LW:   begin alu_src_b = 1'b1; state_d = S_MEM; end
          C_SW:   begin alu_src_b = 1'b1; state_d = S_MEM; end
          C_BEQ:  begin npc_op = NPC_BRANCH; pc_write = zero;  retire = 1'b1; state_d = S_FETCH; end
          C_BNE:  begin npc_op = NPC_BRANCH; pc_write = ~zero; retire = 1'b1; state_d = S_FETCH; end
          C_J:    begin npc_op = NPC_JUMP;   pc_write = 1'b1;  retire = 1'b1; state_d = S_FETCH; end
          C_JAL: begin
            npc_op    = NPC_JUMP;
            pc_write  = 1'b1;
            reg_write = 1'b1;
            gpr_sel   = GPR_R31;
            wd_sel    = WD_PC;
            retire    = 1'b1;
            state_d   = S_FETCH;
          end
          C_JR:    begin npc_op = NPC_JR; pc_write = 1'b1; retire = 1'b1; state_d = S_FETCH; end
          default: state_d = S_TRAP;
        endcase
      end
      S_MEM: begin
        // The store strobe stays up through wait states; only retire waits for ready.
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = (dec_cls == C_SW);
        if (mem_ready) begin
          if (dec_cls == C_SW) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else begin
          state_d = S_MEM;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        gpr_sel   = (dec_cls == C_RALU) ? GPR_RD : GPR_RT;
        wd_sel    = (dec_cls == C_LW)   ? WD_MEM : WD_ALU;
        state_d   = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    if (retire) cnt_d = cnt_q + CNT_ONE;
    else        cnt_d = cnt_q;
  end

  assign illegal   = illegal_q;
  assign instr_cnt = cnt_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: a per-instruction cycle script derived from
// the instruction rules, driven by a vector table, random traffic and hand sequences.
module tb_mc_ctrl;
  import mc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [5:0] op = 6'd0, funct = 6'd0;
  logic zero = 1'b0, mem_ready = 1'b0;

  logic mem_req, mem_we, iord, ir_write, pc_write, reg_write, alu_src_a, alu_src_b, ext_op;
  logic illegal, retire;
  logic [3:0] alu_op;
  logic [1:0] npc_op, wd_sel, gpr_sel;
  logic [31:0] instr_cnt;
  logic [2:0] state_o;

  logic s_mem_req, s_mem_we, s_iord, s_ir_write, s_pc_write, s_reg_write, s_alu_src_a, s_alu_src_b, s_ext_op;
  logic s_illegal, s_retire;
  logic [3:0] s_alu_op;
  logic [1:0] s_npc_op, s_wd_sel, s_gpr_sel;
  logic [2:0] s_instr_cnt;
  logic [2:0] s_state_o;

  typedef struct packed {
    logic mem_req, mem_we, iord, ir_write, pc_write, reg_write, alu_src_a, alu_src_b, ext_op;
    logic [3:0] alu_op;
    logic [1:0] npc_op, wd_sel, gpr_sel;
    logic retire;
    logic [2:0] st;
  } ov_t;

  typedef struct packed {
    logic [3:0] kind;
    logic [3:0] alu;
    logic ext;
    logic shift;
  } info_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] funct;
    logic z;
    int fw;
    int mw;
    int lat;
  } vec_t;

  localparam logic [3:0] K_RALU = 4'd0, K_IMM = 4'd1, K_LW = 4'd2, K_SW = 4'd3, K_BEQ = 4'd4,
                         K_BNE = 4'd5, K_J = 4'd6, K_JAL = 4'd7, K_JR = 4'd8, K_ILL = 4'd9;

  ov_t act, s_act;
  assign act = {mem_req, mem_we, iord, ir_write, pc_write, reg_write, alu_src_a, alu_src_b, ext_op,
                alu_op, npc_op, wd_sel, gpr_sel, retire, state_o};
  assign s_act = {s_mem_req, s_mem_we, s_iord, s_ir_write, s_pc_write, s_reg_write, s_alu_src_a,
                  s_alu_src_b, s_ext_op, s_alu_op, s_npc_op, s_wd_sel, s_gpr_sel, s_retire, s_state_o};

  int checks = 0;
  int errors = 0;
  logic [31:0] model_cnt = 32'd0;
  logic model_ill = 1'b0;

  mc_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write), .pc_write(pc_write),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_op(ext_op),
    .alu_op(alu_op), .npc_op(npc_op), .wd_sel(wd_sel), .gpr_sel(gpr_sel), .illegal(illegal),
    .retire(retire), .instr_cnt(instr_cnt), .state_o(state_o)
  );

  // Narrow counter copy: exercises wrap-around after only 8 retires.
  mc_ctrl #(.CNT_W(3)) u_small (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_req(s_mem_req), .mem_we(s_mem_we), .iord(s_iord), .ir_write(s_ir_write), .pc_write(s_pc_write),
    .reg_write(s_reg_write), .alu_src_a(s_alu_src_a), .alu_src_b(s_alu_src_b), .ext_op(s_ext_op),
    .alu_op(s_alu_op), .npc_op(s_npc_op), .wd_sel(s_wd_sel), .gpr_sel(s_gpr_sel), .illegal(s_illegal),
    .retire(s_retire), .instr_cnt(s_instr_cnt), .state_o(s_state_o)
  );

  always #5 clk = ~clk;

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic ov_t st_vec(input logic [2:0] s);
    ov_t e;
    e = '0;
    e.st = s;
    return e;
  endfunction

  function automatic info_t ref_info(input logic [5:0] o, input logic [5:0] f);
    info_t r;
    r = '{kind: K_ILL, alu: ALU_ADD, ext: 1'b1, shift: 1'b0};
    case (o)
      OP_RTYPE: begin
        case (f)
          FN_ADD:  r.kind = K_RALU;
          FN_SUB:  begin r.kind = K_RALU; r.alu = ALU_SUB; end
          FN_AND:  begin r.kind = K_RALU; r.alu = ALU_AND; end
          FN_OR:   begin r.kind = K_RALU; r.alu = ALU_OR;  end
          FN_SLT:  begin r.kind = K_RALU; r.alu = ALU_SLT; end
          FN_SLL:  begin r.kind = K_RALU; r.alu = ALU_SLL; r.shift = 1'b1; end
          FN_SRL:  begin r.kind = K_RALU; r.alu = ALU_SRL; r.shift = 1'b1; end
          FN_JR:   r.kind = K_JR;
          default: r.kind = K_ILL;
        endcase
      end
      OP_ADDI: r.kind = K_IMM;
      OP_ORI:  begin r.kind = K_IMM; r.alu = ALU_OR;  r.ext = 1'b0; end
      OP_LUI:  begin r.kind = K_IMM; r.alu = ALU_LUI; r.ext = 1'b0; end
      OP_LW:   r.kind = K_LW;
      OP_SW:   r.kind = K_SW;
      OP_BEQ:  begin r.kind = K_BEQ; r.alu = ALU_SUB; end
      OP_BNE:  begin r.kind = K_BNE; r.alu = ALU_SUB; end
      OP_J:    r.kind = K_J;
      OP_JAL:  r.kind = K_JAL;
      default: r.kind = K_ILL;
    endcase
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, a, e, $time);
    end
  endtask

  // Entered just after a rising edge; applies inputs, checks mid-cycle, leaves after the next edge.
  task automatic cyc(input ov_t e, input logic rdy, input logic z, input string nm);
    mem_ready = rdy;
    zero = z;
    @(negedge clk);
    chk(nm, 64'(act), 64'(e));
    chk({nm, "_small"}, 64'(s_act), 64'(e));
    chk({nm, "_cnt"}, 64'(instr_cnt), 64'(model_cnt));
    chk({nm, "_cnt3"}, 64'(s_instr_cnt), 64'(model_cnt[2:0]));
    chk({nm, "_illegal"}, 64'(illegal), 64'(model_ill));
    if (e.retire) model_cnt = model_cnt + 32'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_cnt = 32'd0;
    model_ill = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", 64'(act), 64'(st_vec(3'd0)));
    chk("reset_cnt", 64'(instr_cnt), 64'd0);
    chk("reset_illegal", 64'(illegal), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc(st_vec(3'd0), rb(), rb(), "idle");
  endtask

  task automatic exec(input logic [5:0] o, input logic [5:0] f, input logic z,
                      input int fw, input int mw, output int n);
    info_t inf;
    ov_t e;
    inf = ref_info(o, f);
    n = 0;
    op = o;
    funct = f;
    for (int i = 0; i < fw; i++) begin
      e = st_vec(3'd1); e.mem_req = 1'b1;
      cyc(e, 1'b0, rb(), "fetch_wait"); n++;
    end
    e = st_vec(3'd1); e.mem_req = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
    cyc(e, 1'b1, rb(), "fetch"); n++;
    cyc(st_vec(3'd2), rb(), rb(), "decode"); n++;
    op = 6'($urandom);
    funct = 6'($urandom);
    if (inf.kind == K_ILL) begin
      model_ill = 1'b1;
      for (int i = 0; i < 4; i++) begin
        cyc(st_vec(3'd6), rb(), rb(), "trap"); n++;
      end
      return;
    end
    e = st_vec(3'd3);
    e.alu_op = inf.alu; e.ext_op = inf.ext; e.alu_src_a = inf.shift;
    case (inf.kind)
      K_IMM, K_LW, K_SW: e.alu_src_b = 1'b1;
      K_BEQ: begin e.npc_op = NPC_BRANCH; e.pc_write = z;  e.retire = 1'b1; end
      K_BNE: begin e.npc_op = NPC_BRANCH; e.pc_write = ~z; e.retire = 1'b1; end
      K_J:   begin e.npc_op = NPC_JUMP; e.pc_write = 1'b1; e.retire = 1'b1; end
      K_JAL: begin
        e.npc_op = NPC_JUMP; e.pc_write = 1'b1; e.retire = 1'b1;
        e.reg_write = 1'b1; e.gpr_sel = GPR_R31; e.wd_sel = WD_PC;
      end
      K_JR:  begin e.npc_op = NPC_JR; e.pc_write = 1'b1; e.retire = 1'b1; end
      default: ;
    endcase
    cyc(e, rb(), z, "exe"); n++;
    if (inf.kind == K_LW || inf.kind == K_SW) begin
      e = st_vec(3'd4); e.mem_req = 1'b1; e.iord = 1'b1; e.mem_we = (inf.kind == K_SW);
      for (int i = 0; i < mw; i++) begin
        cyc(e, 1'b0, rb(), "mem_wait"); n++;
      end
      e.retire = (inf.kind == K_SW);
      cyc(e, 1'b1, rb(), "mem"); n++;
    end
    if (inf.kind == K_RALU || inf.kind == K_IMM || inf.kind == K_LW) begin
      e = st_vec(3'd5); e.reg_write = 1'b1; e.retire = 1'b1;
      e.gpr_sel = (inf.kind == K_RALU) ? GPR_RD : GPR_RT;
      e.wd_sel = (inf.kind == K_LW) ? WD_MEM : WD_ALU;
      cyc(e, rb(), rb(), "wb"); n++;
    end
  endtask

  initial begin
    vec_t tbl[$];
    logic [5:0] pool_op[15];
    logic [5:0] pool_fn[15];
    int n;
    int k;
    ov_t e;

    tbl.push_back('{OP_RTYPE, FN_ADD, 1'b0, 0, 0, 4});
    tbl.push_back('{OP_LW,    6'h11,  1'b0, 0, 3, 8});
    tbl.push_back('{OP_BEQ,   6'h00,  1'b1, 0, 0, 3});
    tbl.push_back('{OP_BEQ,   6'h00,  1'b0, 0, 0, 3});
    tbl.push_back('{OP_JAL,   6'h3F,  1'b0, 0, 0, 3});
    tbl.push_back('{OP_RTYPE, FN_SUB, 1'b0, 0, 0, 4});
    tbl.push_back('{OP_RTYPE, FN_AND, 1'b0, 0, 0, 4});
    tbl.push_back('{OP_RTYPE, FN_OR,  1'b0, 0, 0, 4});
    tbl.push_back('{OP_RTYPE, FN_SLT, 1'b0, 0, 0, 4});
    tbl.push_back('{OP_RTYPE, FN_SLL, 1'b0, 0, 0, 4});
    tbl.push_back('{OP_RTYPE, FN_SRL, 1'b0, 0, 0, 4});
    tbl.push_back('{OP_RTYPE, FN_JR,  1'b0, 0, 0, 3});
    tbl.push_back('{OP_ADDI,  6'h20,  1'b0, 0, 0, 4});
    tbl.push_back('{OP_ORI,   6'h00,  1'b0, 0, 0, 4});
    tbl.push_back('{OP_LUI,   6'h08,  1'b0, 0, 0, 4});
    tbl.push_back('{OP_SW,    6'h00,  1'b0, 0, 0, 4});
    tbl.push_back('{OP_SW,    6'h2B,  1'b0, 1, 2, 7});
    tbl.push_back('{OP_BNE,   6'h00,  1'b0, 0, 0, 3});
    tbl.push_back('{OP_BNE,   6'h00,  1'b1, 0, 0, 3});
    tbl.push_back('{OP_J,     6'h00,  1'b0, 0, 0, 3});
    tbl.push_back('{OP_LW,    6'h00,  1'b0, 0, 0, 5});
    tbl.push_back('{OP_ADDI,  6'h00,  1'b0, 2, 0, 6});

    pool_op = '{OP_RTYPE, OP_RTYPE, OP_RTYPE, OP_RTYPE, OP_RTYPE, OP_RTYPE, OP_RTYPE, OP_RTYPE,
                OP_ADDI, OP_ORI, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_BNE};
    pool_fn = '{FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SLL, FN_SRL, FN_JR,
                6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

    do_reset();
    foreach (tbl[i]) begin
      exec(tbl[i].op, tbl[i].funct, tbl[i].z, tbl[i].fw, tbl[i].mw, n);
      chk($sformatf("latency_%0d", i), 64'(n), 64'(tbl[i].lat));
    end

    for (int i = 0; i < 300; i++) begin
      k = $urandom_range(0, 16);
      if (k == 15)      exec(OP_J,   6'($urandom), rb(), $urandom_range(0, 2), 0, n);
      else if (k == 16) exec(OP_JAL, 6'($urandom), rb(), $urandom_range(0, 2), 0, n);
      else if (pool_op[k] == OP_RTYPE)
        exec(pool_op[k], pool_fn[k], rb(), $urandom_range(0, 2), $urandom_range(0, 3), n);
      else
        exec(pool_op[k], 6'($urandom), rb(), $urandom_range(0, 2), $urandom_range(0, 3), n);
    end

    do_reset();
    exec(6'h3F, 6'h00, 1'b0, 0, 0, n);
    do_reset();
    exec(OP_RTYPE, 6'h21, 1'b0, 1, 0, n);

    // Asynchronous reset while a load is stalled in MEM.
    do_reset();
    exec(OP_RTYPE, FN_ADD, 1'b0, 0, 0, n);
    op = OP_LW;
    funct = 6'h00;
    e = st_vec(3'd1); e.mem_req = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
    cyc(e, 1'b1, 1'b0, "ar_fetch");
    cyc(st_vec(3'd2), 1'b0, 1'b0, "ar_decode");
    e = st_vec(3'd3); e.alu_src_b = 1'b1; e.ext_op = 1'b1; e.alu_op = ALU_ADD;
    cyc(e, 1'b0, 1'b0, "ar_exe");
    e = st_vec(3'd4); e.mem_req = 1'b1; e.iord = 1'b1;
    cyc(e, 1'b0, 1'b0, "ar_mem_wait");
    mem_ready = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_outs", 64'(act), 64'(st_vec(3'd0)));
    chk("async_rst_cnt", 64'(instr_cnt), 64'd0);
    chk("async_rst_cnt3", 64'(s_instr_cnt), 64'd0);
    model_cnt = 32'd0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc(st_vec(3'd0), 1'b1, 1'b0, "ar_idle");
    exec(OP_RTYPE, FN_ADD, 1'b0, 0, 0, n);
    chk("ar_resume_cnt", 64'(instr_cnt), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
